majority_voter_seq: RTL and testbench

- Registered, parametrised N-channel bitwise majority voter; next generation of the team's 3-input combinational voter.
- Adds:
  - per-channel disagreement tracking;
  - automatic exclusion of a persistently faulty channel;
  - tie detection when an even number of channels remain active.
- Sits between redundant sensor/logic replicas and downstream consumers; output is registered with 1-cycle latency.

---
 rtl/majority_voter_seq_if.sv | 25 ++
 rtl/majority_voter_seq.sv | 110 +++++++++++
 tb/tb_majority_voter_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/majority_voter_seq_if.sv
// Sample/vote bundle for majority_voter_seq: replica words in, voted word and fault status out.
// Master drives samples and fault clearing; slave (the voter) returns registered results.
interface majority_voter_seq_if #(
  parameter int N     = 3,
  parameter int WIDTH = 1
);
  logic               in_valid;
  logic [N*WIDTH-1:0] y_in;
  logic               clr_faults;
  logic [WIDTH-1:0]   y;
  logic               y_valid;
  logic [N-1:0]       mismatch;
  logic [N-1:0]       excluded;
  logic               no_majority;

  modport master (
    output in_valid, y_in, clr_faults,
    input  y, y_valid, mismatch, excluded, no_majority
  );

  modport slave (
    input  in_valid, y_in, clr_faults,
    output y, y_valid, mismatch, excluded, no_majority
  );
endinterface

// File: rtl/majority_voter_seq.sv
// N-channel bitwise majority voter with per-channel fault counting and automatic exclusion.
// 1-cycle sample-to-output latency; no backpressure, every in_valid cycle is accepted.
module majority_voter_seq #(
  parameter int N           = 3,
  parameter int WIDTH       = 1,
  parameter int FAULT_LIMIT = 4,
  parameter int CNT_W       = 3
) (
  input logic               clk,
  input logic               rst_n,
  majority_voter_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(FAULT_LIMIT);

  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] vote;
  logic             yv_q;
  logic             nm_q;
  logic             tie_any;
  logic [N-1:0]     mm_q;
  logic [N-1:0]     mm_d;
  logic [N-1:0]     excl_q;
  logic [N-1:0]     excl_d;
  logic [N-1:0]     hit;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  int               act_cnt;

  // Per-bit vote over active channels; a tied bit keeps the last registered value.
  always_comb begin
    int ones;
    act_cnt = 0;
    for (int k = 0; k < N; k++) begin
      if (!excl_q[k]) act_cnt++;
    end
    vote    = y_q;
    tie_any = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      ones = 0;
      for (int k = 0; k < N; k++) begin
        if (!excl_q[k] && bus.y_in[k*WIDTH+b]) ones++;
      end
      if (2*ones > act_cnt)      vote[b] = 1'b1;
      else if (2*ones < act_cnt) vote[b] = 1'b0;
      else                       tie_any = 1'b1;
    end
  end

  always_comb begin
    int remain;
    mm_d = '0;
    hit  = '0;
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = cnt_q[k];
      if (!excl_q[k]) begin
        mm_d[k] = (bus.y_in[k*WIDTH +: WIDTH] != vote);
        if (mm_d[k]) begin
          if (cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + 1'b1;
          hit[k] = (cnt_d[k] >= LIMIT);
        end else begin
          cnt_d[k] = '0;
        end
      end
    end
    // Lowest index wins; never let the active set fall below two voters.
    excl_d = excl_q;
    remain = act_cnt;
    for (int k = 0; k < N; k++) begin
      if (hit[k] && remain > 2) begin
        excl_d[k] = 1'b1;
        remain--;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      yv_q   <= 1'b0;
      nm_q   <= 1'b0;
      mm_q   <= '0;
      excl_q <= '0;
      for (int k = 0; k < N; k++) cnt_q[k] <= '0;
    end else begin
      yv_q <= bus.in_valid;
      if (bus.in_valid) begin
        y_q  <= vote;
        mm_q <= mm_d;
        nm_q <= tie_any;
      end
      // Clearing outranks fault tracking, but the coincident sample is still voted above.
      if (bus.clr_faults) begin
        excl_q <= '0;
        for (int k = 0; k < N; k++) cnt_q[k] <= '0;
      end else if (bus.in_valid) begin
        excl_q <= excl_d;
        for (int k = 0; k < N; k++) cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign bus.y           = y_q;
  assign bus.y_valid     = yv_q;
  assign bus.mismatch    = mm_q;
  assign bus.excluded    = excl_q;
  assign bus.no_majority = nm_q;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Scoreboard bench for majority_voter_seq: a 3x1 and a 5x4 instance against a queue-fed reference model.
module tb_majority_voter_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  majority_voter_seq_if #(.N(3), .WIDTH(1)) ifc0 ();
  majority_voter_seq_if #(.N(5), .WIDTH(4)) ifc1 ();

  majority_voter_seq #(.N(3), .WIDTH(1), .FAULT_LIMIT(4), .CNT_W(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
  majority_voter_seq #(.N(5), .WIDTH(4), .FAULT_LIMIT(4), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(ifc1.slave));

  typedef struct packed {
    logic [7:0] y;
    logic [6:0] mm;
    logic       nm;
    logic [6:0] ex;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: exclusion flags, consecutive-miss counts, last voted word.
  bit         ex_m [2][7];
  int         cnt_m [2][7];
  logic [7:0] yp_m [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear(input int d);
    for (int k = 0; k < 7; k++) begin
      ex_m[d][k]  = 1'b0;
      cnt_m[d][k] = 0;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      yp_m[d] = '0;
    end
  endtask

  task automatic model_step(input int d, input int n, input int w, input logic [55:0] yin,
                            input logic clr, output exp_t e);
    int a, ones, zeros, rem, old;
    logic [7:0] v;
    logic [6:0] mm;
    logic       nm;
    a = 0;
    for (int k = 0; k < n; k++) if (!ex_m[d][k]) a++;
    v  = yp_m[d];
    nm = 1'b0;
    mm = '0;
    for (int b = 0; b < w; b++) begin
      ones = 0;
      for (int k = 0; k < n; k++) if (!ex_m[d][k] && yin[k*w+b]) ones++;
      zeros = a - ones;
      if (ones > zeros)      v[b] = 1'b1;
      else if (zeros > ones) v[b] = 1'b0;
      else                   nm = 1'b1;
    end
    for (int k = 0; k < n; k++)
      if (!ex_m[d][k])
        for (int b = 0; b < w; b++) if (yin[k*w+b] != v[b]) mm[k] = 1'b1;
    rem = a;
    for (int k = 0; k < n; k++) begin
      if (!ex_m[d][k]) begin
        old = cnt_m[d][k];
        cnt_m[d][k] = mm[k] ? ((old == 7) ? 7 : old + 1) : 0;
        if (old < 4 && cnt_m[d][k] >= 4 && rem > 2) begin
          ex_m[d][k] = 1'b1;
          rem--;
        end
      end
    end
    if (clr) model_clear(d);
    yp_m[d] = v;
    e.y  = v;
    e.mm = mm;
    e.nm = nm;
    e.ex = '0;
    for (int k = 0; k < n; k++) e.ex[k] = ex_m[d][k];
  endtask

  task automatic send0(input logic v, input logic [2:0] yin, input logic clr);
    exp_t e;
    @(negedge clk);
    ifc0.in_valid   = v;
    ifc0.y_in       = yin;
    ifc0.clr_faults = clr;
    if (v) begin
      model_step(0, 3, 1, {53'b0, yin}, clr, e);
      q0.push_back(e);
    end else if (clr) begin
      model_clear(0);
    end
    @(posedge clk);
    #1;
    ifc0.in_valid   = 1'b0;
    ifc0.clr_faults = 1'b0;
  endtask

  task automatic send1(input logic v, input logic [19:0] yin, input logic clr);
    exp_t e;
    @(negedge clk);
    ifc1.in_valid   = v;
    ifc1.y_in       = yin;
    ifc1.clr_faults = clr;
    if (v) begin
      model_step(1, 5, 4, {36'b0, yin}, clr, e);
      q1.push_back(e);
    end else if (clr) begin
      model_clear(1);
    end
    @(posedge clk);
    #1;
    ifc1.in_valid   = 1'b0;
    ifc1.clr_faults = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifc0.y_valid) begin
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL d0.spurious: y_valid=1 with nothing expected");
      end else begin
        e = q0.pop_front();
        chk("d0.y",  32'(ifc0.y),           32'(e.y[0]));
        chk("d0.mm", 32'(ifc0.mismatch),    32'(e.mm[2:0]));
        chk("d0.nm", 32'(ifc0.no_majority), 32'(e.nm));
        chk("d0.ex", 32'(ifc0.excluded),    32'(e.ex[2:0]));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifc1.y_valid) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL d1.spurious: y_valid=1 with nothing expected");
      end else begin
        e = q1.pop_front();
        chk("d1.y",  32'(ifc1.y),           32'(e.y[3:0]));
        chk("d1.mm", 32'(ifc1.mismatch),    32'(e.mm[4:0]));
        chk("d1.nm", 32'(ifc1.no_majority), 32'(e.nm));
        chk("d1.ex", 32'(ifc1.excluded),    32'(e.ex[4:0]));
      end
    end
  end

  initial begin
    exp_t        e;
    int          f;
    logic [2:0]  r3;
    logic        base;
    logic [3:0]  base4;
    logic [3:0]  word;
    logic [19:0] r20;

    rst_n = 1'b0;
    ifc0.in_valid = 1'b0; ifc0.y_in = '0; ifc0.clr_faults = 1'b0;
    ifc1.in_valid = 1'b0; ifc1.y_in = '0; ifc1.clr_faults = 1'b0;
    model_reset();
    #1;
    chk("rst.y",  32'(ifc0.y),           0);
    chk("rst.yv", 32'(ifc0.y_valid),     0);
    chk("rst.mm", 32'(ifc0.mismatch),    0);
    chk("rst.ex", 32'(ifc0.excluded),    0);
    chk("rst.nm", 32'(ifc0.no_majority), 0);
    chk("rst.y1", 32'(ifc1.y),           0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic voting
    send0(1, 3'b100, 0);
    send0(1, 3'b110, 0);
    send0(1, 3'b011, 0);
    send0(0, 3'b000, 1);

    // ch0 stuck high until excluded, then a unanimous sample
    repeat (4) send0(1, 3'b001, 0);
    send0(1, 3'b111, 0);

    // Two voters left: force y to 0, then keep them tied
    send0(1, 3'b000, 0);
    repeat (6) send0(1, 3'b010, 0);

    // Clear coincident with a sample, then a sample that needs all three voters
    send0(1, 3'b011, 1);
    send0(1, 3'b011, 0);

    // Wide instance
    send1(1, 20'hFA5AA, 0);

    for (int i = 0; i < 300; i++) begin
      f    = (i / 50) % 3;
      base = 1'($urandom);
      r3   = {3{base}};
      r3[f] = ((i % 50) < 25) ? ~base : 1'($urandom);
      if ($urandom_range(0, 7) == 0) r3[$urandom_range(0, 2)] = 1'($urandom);
      send0(1'($urandom_range(0, 3) != 0), r3, $urandom_range(0, 39) == 0);
    end

    for (int i = 0; i < 200; i++) begin
      f     = (i / 40) % 5;
      base4 = 4'($urandom);
      for (int k = 0; k < 5; k++) begin
        word = base4;
        if ($urandom_range(0, 3) == 0) word = word ^ 4'($urandom);
        if (k == f && (i % 40) < 20) word = 4'($urandom);
        r20[k*4 +: 4] = word;
      end
      send1(1'($urandom_range(0, 3) != 0), r20, $urandom_range(0, 39) == 0);
    end

    // Exclude ch1 with y=1, then reset asynchronously while y_valid is high
    send0(0, 3'b000, 1);
    repeat (4) send0(1, 3'b101, 0);
    e = q0.pop_front();
    chk("pre_rst.y",  32'(ifc0.y),        32'(e.y[0]));
    chk("pre_rst.ex", 32'(ifc0.excluded), 32'(e.ex[2:0]));
    #2 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    #1;
    chk("arst.y",  32'(ifc0.y),        0);
    chk("arst.ex", 32'(ifc0.excluded), 0);
    chk("arst.mm", 32'(ifc0.mismatch), 0);
    chk("arst.yv", 32'(ifc0.y_valid),  0);
    @(negedge clk);
    rst_n = 1'b1;
    send0(1, 3'b011, 0);

    repeat (4) @(negedge clk);
    chk("d0.drain", 32'(q0.size()), 0);
    chk("d1.drain", 32'(q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
